// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, writeback, lookup, flush and commit signals of the reorder buffer.
//   slave  : the reorder buffer itself (allocates, accepts results, answers lookups, retires).
//   master : the pipeline around it (issue stage, completion ports, branch recovery).
interface reorder_buffer_if;
    logic        alloc;
    logic [4:0]  alloc_rd;
    logic        alloc_we;
    logic [4:0]  alloc_tag;
    logic        full;
    logic        empty;
    logic        wb_valid1;
    logic [4:0]  wb_tag1;
    logic [31:0] wb_value1;
    logic        wb_valid2;
    logic [4:0]  wb_tag2;
    logic [31:0] wb_value2;
    logic [4:0]  q_tag1;
    logic [4:0]  q_tag2;
    logic        q_ready1;
    logic        q_ready2;
    logic [31:0] q_val1;
    logic [31:0] q_val2;
    logic        flush;
    logic        commit_valid;
    logic        commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [4:0]  commit_tag;
    modport slave (
        input  alloc, alloc_rd, alloc_we,
        input  wb_valid1, wb_tag1, wb_value1, wb_valid2, wb_tag2, wb_value2,
        input  q_tag1, q_tag2, flush,
        output alloc_tag, full, empty, q_ready1, q_ready2, q_val1, q_val2,
        output commit_valid, commit_we, commit_rd, commit_value, commit_tag
    );
    modport master (
        output alloc, alloc_rd, alloc_we,
        output wb_valid1, wb_tag1, wb_value1, wb_valid2, wb_tag2, wb_value2,
        output q_tag1, q_tag2, flush,
        input  alloc_tag, full, empty, q_ready1, q_ready2, q_val1, q_val2,
        input  commit_valid, commit_we, commit_rd, commit_value, commit_tag
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order retirement buffer with two completion ports and two operand lookups.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : reorder_buffer_if.slave (alloc/tag/full/empty, wb ports 1-2, lookups 1-2, flush, commit outputs)
// Tags are {1'b1, index}; a tag with bit 4 clear never matches an entry.
module reorder_buffer (
    input  logic           clk_i,
    input  logic           rst_ni,
    reorder_buffer_if.slave bus
);
    logic [15:0] busy_q, done_q, we_q;
    logic [4:0]  rd_q [16];
    logic [31:0] val_q [16];
    logic [3:0]  head_q, tail_q;
    logic [4:0]  count_q, count_d;
    logic        full, alloc_ok, commit, wb1_hit, wb2_hit;
    logic [3:0]  idx1, idx2, qi1, qi2;
    logic        q1_b2, q1_b1, q2_b2, q2_b1;
    logic        commit_valid_q, commit_we_q;
    logic [4:0]  commit_rd_q, commit_tag_q;
    logic [31:0] commit_value_q;

    assign full     = count_q == 5'd16;
    assign idx1     = bus.wb_tag1[3:0];
    assign idx2     = bus.wb_tag2[3:0];
    assign alloc_ok = bus.alloc & ~full & ~bus.flush;
    assign wb1_hit  = bus.wb_valid1 & bus.wb_tag1[4] & busy_q[idx1] & ~bus.flush;
    assign wb2_hit  = bus.wb_valid2 & bus.wb_tag2[4] & busy_q[idx2] & ~bus.flush;
    assign commit   = busy_q[head_q] & done_q[head_q];
    assign count_d  = count_q + 5'(alloc_ok) - 5'(commit);

    assign bus.full      = full;
    assign bus.empty     = count_q == 5'd0;
    assign bus.alloc_tag = {1'b1, tail_q};

    // Operand lookup: same-cycle writeback bypass first (port 2 over port 1), then stored result.
    assign qi1   = bus.q_tag1[3:0];
    assign qi2   = bus.q_tag2[3:0];
    assign q1_b2 = bus.wb_valid2 & (bus.wb_tag2 == bus.q_tag1);
    assign q1_b1 = bus.wb_valid1 & (bus.wb_tag1 == bus.q_tag1);
    assign q2_b2 = bus.wb_valid2 & (bus.wb_tag2 == bus.q_tag2);
    assign q2_b1 = bus.wb_valid1 & (bus.wb_tag1 == bus.q_tag2);
    assign bus.q_ready1 = bus.q_tag1[4] & (q1_b2 | q1_b1 | (busy_q[qi1] & done_q[qi1]));
    assign bus.q_ready2 = bus.q_tag2[4] & (q2_b2 | q2_b1 | (busy_q[qi2] & done_q[qi2]));
    assign bus.q_val1 = !bus.q_ready1 ? 32'd0 : q1_b2 ? bus.wb_value2 : q1_b1 ? bus.wb_value1 : val_q[qi1];
    assign bus.q_val2 = !bus.q_ready2 ? 32'd0 : q2_b2 ? bus.wb_value2 : q2_b1 ? bus.wb_value1 : val_q[qi2];

    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_we    = commit_we_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_value = commit_value_q;
    assign bus.commit_tag   = commit_tag_q;

    // Entry payload carries no reset; busy/done qualify it.
    always_ff @(posedge clk_i) begin
        if (alloc_ok) begin
            rd_q[tail_q] <= bus.alloc_rd;
            we_q[tail_q] <= bus.alloc_we;
        end
        if (wb1_hit) val_q[idx1] <= bus.wb_value1;
        if (wb2_hit) val_q[idx2] <= bus.wb_value2;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
        end else if (bus.flush) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
        end else begin
            // head==tail only when empty (no commit) or full (no alloc), so these never collide.
            if (alloc_ok) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                tail_q         <= tail_q + 4'd1;
            end
            if (wb1_hit) done_q[idx1] <= 1'b1;
            if (wb2_hit) done_q[idx2] <= 1'b1;
            if (commit) begin
                busy_q[head_q] <= 1'b0;
                head_q         <= head_q + 4'd1;
                commit_rd_q    <= rd_q[head_q];
                commit_value_q <= val_q[head_q];
                commit_tag_q   <= {1'b1, head_q};
            end
            commit_valid_q <= commit;
            commit_we_q    <= commit & we_q[head_q] & (|rd_q[head_q]);
            count_q        <= count_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic against a queue-based in-order model.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if bus();
    reorder_buffer dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic        we;
        logic        done;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    logic        m_cv, m_cwe;
    logic [4:0]  m_crd, m_ctag;
    logic [31:0] m_cval;
    int          checks = 0;
    int          failures = 0;
    logic [4:0]  seen_rd[$];
    logic [31:0] seen_val[$];
    logic        seen_we[$];
    logic        obs_qr1;
    logic [31:0] obs_qv1;
    logic [4:0]  obs_tag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int find(input logic [4:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [32:0] lookup(input logic [4:0] t);
        int i;
        if (!t[4]) return 33'd0;
        if (bus.wb_valid2 && bus.wb_tag2 == t) return {1'b1, bus.wb_value2};
        if (bus.wb_valid1 && bus.wb_tag1 == t) return {1'b1, bus.wb_value1};
        i = find(t);
        if (i >= 0 && mq[i].done) return {1'b1, mq[i].val};
        return 33'd0;
    endfunction

    function automatic logic [4:0] pick();
        if (mq.size() > 0 && $urandom_range(3) != 0) return mq[$urandom_range(mq.size() - 1)].tag;
        return 5'($urandom);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tail = 0;
        m_cv = 1'b0;
        m_cwe = 1'b0;
        m_crd = '0;
        m_cval = '0;
        m_ctag = '0;
    endtask

    task automatic model_edge();
        ent_t h;
        bit c, acc;
        int i;
        if (bus.flush) begin
            mq.delete();
            m_tail = 0;
            m_cv = 1'b0;
            m_cwe = 1'b0;
            return;
        end
        c = mq.size() > 0 && mq[0].done;
        if (c) h = mq[0];
        acc = bus.alloc && mq.size() < 16;
        if (bus.wb_valid1) begin
            i = find(bus.wb_tag1);
            if (i >= 0) begin mq[i].done = 1'b1; mq[i].val = bus.wb_value1; end
        end
        if (bus.wb_valid2) begin
            i = find(bus.wb_tag2);
            if (i >= 0) begin mq[i].done = 1'b1; mq[i].val = bus.wb_value2; end
        end
        if (acc) begin
            mq.push_back('{tag: {1'b1, 4'(m_tail)}, rd: bus.alloc_rd, we: bus.alloc_we, done: 1'b0, val: 32'd0});
            m_tail = (m_tail + 1) % 16;
        end
        if (c) begin
            void'(mq.pop_front());
            m_crd = h.rd;
            m_cval = h.val;
            m_ctag = h.tag;
        end
        m_cv = c;
        m_cwe = c && h.we && h.rd != 5'd0;
    endtask

    task automatic check_comb();
        logic [32:0] e1, e2;
        e1 = lookup(bus.q_tag1);
        e2 = lookup(bus.q_tag2);
        chk("alloc_tag", 32'(bus.alloc_tag), 32'({1'b1, 4'(m_tail)}));
        chk("full", 32'(bus.full), 32'(mq.size() == 16));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("q_ready1", 32'(bus.q_ready1), 32'(e1[32]));
        chk("q_val1", bus.q_val1, e1[31:0]);
        chk("q_ready2", 32'(bus.q_ready2), 32'(e2[32]));
        chk("q_val2", bus.q_val2, e2[31:0]);
    endtask

    task automatic check_commit();
        chk("commit_valid", 32'(bus.commit_valid), 32'(m_cv));
        chk("commit_we", 32'(bus.commit_we), 32'(m_cwe));
        chk("commit_rd", 32'(bus.commit_rd), 32'(m_crd));
        chk("commit_value", bus.commit_value, m_cval);
        chk("commit_tag", 32'(bus.commit_tag), 32'(m_ctag));
        if (bus.commit_valid) begin
            seen_rd.push_back(bus.commit_rd);
            seen_val.push_back(bus.commit_value);
            seen_we.push_back(bus.commit_we);
        end
    endtask

    task automatic idle();
        bus.alloc = 1'b0; bus.alloc_rd = '0; bus.alloc_we = 1'b0;
        bus.wb_valid1 = 1'b0; bus.wb_tag1 = '0; bus.wb_value1 = '0;
        bus.wb_valid2 = 1'b0; bus.wb_tag2 = '0; bus.wb_value2 = '0;
        bus.q_tag1 = '0; bus.q_tag2 = '0; bus.flush = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        check_comb();
        obs_qr1 = bus.q_ready1;
        obs_qv1 = bus.q_val1;
        obs_tag = bus.alloc_tag;
        @(posedge clk);
        model_edge();
        #1;
        check_commit();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_alloc_tag", 32'(bus.alloc_tag), 32'h10);
        check_commit();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic we);
        idle();
        bus.alloc = 1'b1; bus.alloc_rd = rd; bus.alloc_we = we;
        step();
    endtask

    task automatic wb_one(input logic [4:0] t, input logic [31:0] v);
        idle();
        bus.wb_valid1 = 1'b1; bus.wb_tag1 = t; bus.wb_value1 = v;
        step();
    endtask

    task automatic rand_cycle(input int pa);
        idle();
        bus.alloc = $urandom_range(99) < pa;
        bus.alloc_rd = 5'($urandom);
        bus.alloc_we = 1'($urandom);
        bus.wb_valid1 = 1'($urandom);
        bus.wb_tag1 = pick();
        bus.wb_value1 = $urandom;
        bus.wb_valid2 = 1'($urandom);
        bus.wb_tag2 = $urandom_range(7) == 0 ? bus.wb_tag1 : pick();
        bus.wb_value2 = $urandom;
        bus.q_tag1 = pick();
        bus.q_tag2 = $urandom_range(3) == 0 ? bus.wb_tag1 : pick();
        bus.flush = $urandom_range(59) == 0;
        step();
    endtask

    initial begin
        idle();
        do_reset();
        // In-order retirement despite out-of-order completion.
        for (int k = 1; k <= 3; k++) begin
            alloc_one(5'(k), 1'b1);
            chk("t036_tag", 32'(obs_tag), 32'(5'h10 + 5'(k - 1)));
        end
        seen_rd.delete();
        wb_one(5'h12, 32'h1212);
        wb_one(5'h10, 32'h1010);
        wb_one(5'h11, 32'h1111);
        for (int k = 0; k < 3; k++) begin idle(); step(); end
        chk("t036_ncommit", 32'(seen_rd.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen_rd.size(); k++) chk("t036_rd", 32'(seen_rd[k]), 32'(k + 1));

        // Dual writeback to one tag: port 2 wins, and the lookup bypass agrees.
        do_reset();
        for (int k = 0; k < 5; k++) alloc_one(5'(k + 5), 1'b1);
        for (int k = 0; k < 4; k++) wb_one(5'h10 + 5'(k), $urandom);
        seen_val.delete();
        idle();
        bus.wb_valid1 = 1'b1; bus.wb_tag1 = 5'h14; bus.wb_value1 = 32'hAAAA;
        bus.wb_valid2 = 1'b1; bus.wb_tag2 = 5'h14; bus.wb_value2 = 32'hBBBB;
        bus.q_tag1 = 5'h14;
        step();
        chk("t038_qready", 32'(obs_qr1), 32'd1);
        chk("t038_qval", obs_qv1, 32'hBBBB);
        for (int k = 0; k < 6; k++) begin idle(); step(); end
        chk("t038_last_val", seen_val.size() > 0 ? seen_val[seen_val.size() - 1] : 32'hDEAD, 32'hBBBB);

        // Writes to r0 retire without a register write.
        do_reset();
        seen_we.delete();
        seen_val.delete();
        alloc_one(5'd0, 1'b1);
        wb_one(5'h10, 32'h55);
        idle(); step();
        idle(); step();
        chk("t039_ncommit", 32'(seen_we.size()), 32'd1);
        chk("t039_we", seen_we.size() > 0 ? 32'(seen_we[0]) : 32'd1, 32'd0);
        chk("t039_val", seen_val.size() > 0 ? seen_val[0] : 32'd0, 32'h55);

        // Full buffer: extra alloc ignored, slot reused after one retirement.
        do_reset();
        for (int k = 0; k < 16; k++) alloc_one(5'(k), 1'b1);
        chk("t037_full", 32'(bus.full), 32'd1);
        chk("t037_tag", 32'(bus.alloc_tag), 32'h10);
        alloc_one(5'd31, 1'b1);
        chk("t037_full17", 32'(bus.full), 32'd1);
        chk("t037_tag17", 32'(bus.alloc_tag), 32'h10);
        wb_one(5'h10, 32'h77);
        alloc_one(5'd30, 1'b1);
        chk("t037_after_commit_full", 32'(bus.full), 32'd0);
        alloc_one(5'd29, 1'b1);
        chk("t037_reuse_tag", 32'(obs_tag), 32'h10);
        chk("t037_full_again", 32'(bus.full), 32'd1);

        // Flush discards everything, including completed entries.
        do_reset();
        for (int k = 0; k < 5; k++) alloc_one(5'(k + 1), 1'b1);
        wb_one(5'h11, 32'h1);
        wb_one(5'h13, 32'h3);
        idle(); bus.flush = 1'b1; bus.alloc = 1'b1; step();
        chk("t040_empty", 32'(bus.empty), 32'd1);
        chk("t040_cv", 32'(bus.commit_valid), 32'd0);
        chk("t040_tag", 32'(bus.alloc_tag), 32'h10);
        alloc_one(5'd9, 1'b1);
        chk("t040_next_tag", 32'(obs_tag), 32'h10);

        // Asynchronous reset with a commit pending.
        do_reset();
        for (int k = 0; k < 4; k++) alloc_one(5'(k + 1), 1'b1);
        wb_one(5'h10, 32'h99);
        seen_rd.delete();
        do_reset();
        for (int k = 0; k < 3; k++) begin idle(); step(); end
        chk("t041_nocommit", 32'(seen_rd.size()), 32'd0);

        // Random traffic: fill-heavy phase then balanced phase.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(299) == 0) do_reset();
            else rand_cycle(n < 1000 ? 80 : 50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
